// File: rtl/spi_slave_regs_if.sv
// spi_slave_regs_if: SPI mode-0 pin bundle between an SPI host and the register-file target
interface spi_slave_regs_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;
  modport master (output sclk, cs_n, mosi, input miso, miso_oe);
  modport slave (input sclk, cs_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 target exposing a byte-wide register file, oversampled in the clk_50m domain
module spi_slave_regs #(
  parameter int REG_COUNT = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_50m,
  input  logic             reset,
  spi_slave_regs_if.slave  spi,
  input  logic [7:0]       status_in,
  output logic [5:0]       led,
  output logic             wr_strobe,
  output logic [6:0]       wr_addr,
  output logic [7:0]       wr_data
);
  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_e;
  state_e state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
  logic sclk_prev_q, rise_q, fall_q, armed_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shreg_q, addr_q, wr_addr_q;
  logic [7:0] rd_q, wr_data_q;
  logic miso_q, oe_q, strobe_q;
  logic [7:0] regs_q [REG_COUNT];
  logic sclk_s, cs_n_s, mosi_s, in_range;
  logic [7:0] shift_in, rd_val;
  logic [6:0] rd_addr;
  always_comb begin
    sclk_s = sclk_sync_q[SYNC_STAGES-1];
    cs_n_s = cs_sync_q[SYNC_STAGES-1];
    mosi_s = mosi_sync_q[SYNC_STAGES-1];
    shift_in = {shreg_q, mosi_s};
    rd_addr = state_q == CMD ? shift_in[6:0] : addr_q + 7'd1;
    rd_val = rd_addr == 7'h7F ? status_in : 8'h00;
    for (int i = 0; i < REG_COUNT; i++)
      if (rd_addr == 7'(i)) rd_val = regs_q[i];
    in_range = {1'b0, addr_q} < 8'(REG_COUNT);
  end
  // armed_q blocks decoding until cs_n has been seen high with a refilled synchroniser
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q <= '1;
      mosi_sync_q <= '0;
      fill_q <= '0;
      sclk_prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      rise_q <= sclk_s & ~sclk_prev_q;
      fall_q <= ~sclk_s & sclk_prev_q;
      armed_q <= armed_q | (cs_n_s & fill_q[SYNC_STAGES-1]);
    end
  end
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      shreg_q <= '0;
      addr_q <= '0;
      rd_q <= '0;
      miso_q <= 1'b0;
      oe_q <= 1'b0;
      strobe_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (cs_n_s) begin
        state_q <= IDLE;
        oe_q <= 1'b0;
        miso_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (armed_q) begin
            state_q <= CMD;
            bit_cnt_q <= '0;
            oe_q <= 1'b1;
            miso_q <= 1'b0;
          end
          CMD: if (rise_q) begin
            shreg_q <= shift_in[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (&bit_cnt_q) begin
              addr_q <= shift_in[6:0];
              rd_q <= rd_val;
              state_q <= shift_in[7] ? RD : WR;
            end
          end
          WR: if (rise_q) begin
            shreg_q <= shift_in[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (&bit_cnt_q) begin
              addr_q <= addr_q + 7'd1;
              if (in_range) begin
                strobe_q <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= shift_in;
              end
              for (int i = 0; i < REG_COUNT; i++)
                if (addr_q == 7'(i)) regs_q[i] <= shift_in;
            end
          end
          RD: if (fall_q) begin
            miso_q <= rd_q[7];
            rd_q <= {rd_q[6:0], 1'b0};
          end else if (rise_q) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (&bit_cnt_q) begin
              addr_q <= addr_q + 7'd1;
              rd_q <= rd_val;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign spi.miso = miso_q;
  assign spi.miso_oe = oe_q;
  assign led = regs_q[0][5:0];
  assign wr_strobe = strobe_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: directed SPI host frames against spi_slave_regs with hand-computed expectations
module tb_spi_slave_regs;
  logic clk_50m = 1'b0;
  logic reset = 1'b1;
  logic [7:0] status_in = 8'h00;
  logic [5:0] led;
  logic wr_strobe;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  int pass_cnt = 0;
  int total = 0;
  int strobe_cnt = 0;
  logic [6:0] last_addr = '0;
  logic [7:0] last_data = '0;
  spi_slave_regs_if sif();
  spi_slave_regs dut (
    .clk_50m(clk_50m),
    .reset(reset),
    .spi(sif),
    .status_in(status_in),
    .led(led),
    .wr_strobe(wr_strobe),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );
  always #10 clk_50m = ~clk_50m;
  always @(negedge clk_50m) if (wr_strobe === 1'b1) begin
    strobe_cnt++;
    last_addr = wr_addr;
    last_data = wr_data;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      sif.mosi = tx[i];
      repeat (5) @(negedge clk_50m);
      sif.sclk = 1'b1;
      rx = {rx[6:0], sif.miso};
      repeat (5) @(negedge clk_50m);
      sif.sclk = 1'b0;
    end
  endtask
  task automatic cs_low();
    @(negedge clk_50m);
    sif.cs_n = 1'b0;
    repeat (6) @(negedge clk_50m);
  endtask
  task automatic cs_high();
    repeat (5) @(negedge clk_50m);
    sif.cs_n = 1'b1;
    repeat (8) @(negedge clk_50m);
  endtask
  task automatic test_reset();
    sif.sclk = 1'b0; sif.cs_n = 1'b1; sif.mosi = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk_50m);
    total++; if (led !== 6'h00) $display("FAIL reset_led: got %h want %h", led, 6'h00); else pass_cnt++;
    total++; if (sif.miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", sif.miso); else pass_cnt++;
    total++; if (sif.miso_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", sif.miso_oe); else pass_cnt++;
    total++; if (wr_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", wr_strobe); else pass_cnt++;
    total++; if (wr_addr !== 7'h00) $display("FAIL reset_wr_addr: got %h want 00", wr_addr); else pass_cnt++;
    total++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", wr_data); else pass_cnt++;
    reset = 1'b0;
    repeat (4) @(negedge clk_50m);
  endtask
  task automatic test_single_write();
    logic [7:0] rx;
    int c0;
    c0 = strobe_cnt;
    cs_low();
    total++; if (sif.miso_oe !== 1'b1) $display("FAIL sw_oe_selected: got %b want 1", sif.miso_oe); else pass_cnt++;
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h2A, 7, rx);
    sif.mosi = 1'b0;
    repeat (5) @(negedge clk_50m);
    sif.sclk = 1'b1;
    repeat (3) @(negedge clk_50m);
    total++; if (wr_strobe !== 1'b0) $display("FAIL sw_strobe_early: got %b want 0", wr_strobe); else pass_cnt++;
    total++; if (led !== 6'h00) $display("FAIL sw_led_early: got %h want 00", led); else pass_cnt++;
    @(negedge clk_50m);
    total++; if (wr_strobe !== 1'b1) $display("FAIL sw_strobe_at_4: got %b want 1", wr_strobe); else pass_cnt++;
    total++; if (wr_addr !== 7'h00) $display("FAIL sw_wr_addr: got %h want 00", wr_addr); else pass_cnt++;
    total++; if (wr_data !== 8'h2A) $display("FAIL sw_wr_data: got %h want 2a", wr_data); else pass_cnt++;
    total++; if (led !== 6'b101010) $display("FAIL sw_led: got %b want 101010", led); else pass_cnt++;
    repeat (2) @(negedge clk_50m);
    sif.sclk = 1'b0;
    cs_high();
    total++; if (strobe_cnt - c0 !== 1) $display("FAIL sw_strobe_count: got %0d want 1", strobe_cnt - c0); else pass_cnt++;
    total++; if (sif.miso_oe !== 1'b0) $display("FAIL sw_oe_deselected: got %b want 0", sif.miso_oe); else pass_cnt++;
  endtask
  task automatic test_burst_write();
    logic [7:0] rx;
    int c0;
    c0 = strobe_cnt;
    cs_low();
    spi_bits(8'h06, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    spi_bits(8'h33, 8, rx);
    cs_high();
    total++; if (strobe_cnt - c0 !== 2) $display("FAIL bw_strobe_count: got %0d want 2", strobe_cnt - c0); else pass_cnt++;
    total++; if (last_addr !== 7'h07) $display("FAIL bw_last_addr: got %h want 07", last_addr); else pass_cnt++;
    total++; if (last_data !== 8'h22) $display("FAIL bw_last_data: got %h want 22", last_data); else pass_cnt++;
  endtask
  task automatic test_burst_read();
    logic [7:0] rx;
    cs_low();
    spi_bits(8'h86, 8, rx);
    total++; if (rx !== 8'h00) $display("FAIL br_cmd_miso: got %h want 00", rx); else pass_cnt++;
    spi_bits(8'h00, 8, rx);
    total++; if (rx !== 8'h11) $display("FAIL br_reg6: got %h want 11", rx); else pass_cnt++;
    total++; if (sif.miso_oe !== 1'b1) $display("FAIL br_oe_selected: got %b want 1", sif.miso_oe); else pass_cnt++;
    spi_bits(8'h00, 8, rx);
    total++; if (rx !== 8'h22) $display("FAIL br_reg7: got %h want 22", rx); else pass_cnt++;
    cs_high();
    total++; if (sif.miso_oe !== 1'b0) $display("FAIL br_oe_deselected: got %b want 0", sif.miso_oe); else pass_cnt++;
    total++; if (sif.miso !== 1'b0) $display("FAIL br_miso_idle: got %b want 0", sif.miso); else pass_cnt++;
  endtask
  task automatic test_status();
    logic [7:0] rx;
    int c0;
    status_in = 8'h5C;
    cs_low();
    spi_bits(8'hFF, 8, rx);
    spi_bits(8'h00, 8, rx);
    total++; if (rx !== 8'h5C) $display("FAIL st_status: got %h want 5c", rx); else pass_cnt++;
    spi_bits(8'h00, 8, rx);
    total++; if (rx !== 8'h2A) $display("FAIL st_wrap_reg0: got %h want 2a", rx); else pass_cnt++;
    cs_high();
    c0 = strobe_cnt;
    cs_low();
    spi_bits(8'h7F, 8, rx);
    spi_bits(8'hAA, 8, rx);
    cs_high();
    total++; if (strobe_cnt - c0 !== 0) $display("FAIL st_write_strobe: got %0d want 0", strobe_cnt - c0); else pass_cnt++;
    total++; if (led !== 6'b101010) $display("FAIL st_led_kept: got %b want 101010", led); else pass_cnt++;
    cs_low();
    spi_bits(8'h90, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_high();
    total++; if (rx !== 8'h00) $display("FAIL st_unmapped: got %h want 00", rx); else pass_cnt++;
  endtask
  task automatic test_abort();
    logic [7:0] rx;
    int c0;
    c0 = strobe_cnt;
    cs_low();
    spi_bits(8'h00, 8, rx);
    spi_bits(8'hFF, 5, rx);
    cs_high();
    total++; if (strobe_cnt - c0 !== 0) $display("FAIL ab_strobe: got %0d want 0", strobe_cnt - c0); else pass_cnt++;
    total++; if (led !== 6'b101010) $display("FAIL ab_led_kept: got %b want 101010", led); else pass_cnt++;
    cs_low();
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h01, 8, rx);
    cs_high();
    total++; if (strobe_cnt - c0 !== 1) $display("FAIL ab_next_strobe: got %0d want 1", strobe_cnt - c0); else pass_cnt++;
    total++; if (last_data !== 8'h01) $display("FAIL ab_next_data: got %h want 01", last_data); else pass_cnt++;
    total++; if (led !== 6'b000001) $display("FAIL ab_next_led: got %b want 000001", led); else pass_cnt++;
  endtask
  task automatic test_midframe_reset();
    logic [7:0] rx;
    int c0;
    cs_low();
    spi_bits(8'h01, 8, rx);
    @(negedge clk_50m);
    reset = 1'b1;
    @(negedge clk_50m);
    reset = 1'b0;
    total++; if (led !== 6'h00) $display("FAIL mr_led: got %h want 00", led); else pass_cnt++;
    total++; if (sif.miso_oe !== 1'b0) $display("FAIL mr_oe: got %b want 0", sif.miso_oe); else pass_cnt++;
    total++; if (sif.miso !== 1'b0) $display("FAIL mr_miso: got %b want 0", sif.miso); else pass_cnt++;
    total++; if (wr_data !== 8'h00) $display("FAIL mr_wr_data: got %h want 00", wr_data); else pass_cnt++;
    total++; if (wr_addr !== 7'h00) $display("FAIL mr_wr_addr: got %h want 00", wr_addr); else pass_cnt++;
    c0 = strobe_cnt;
    spi_bits(8'h3C, 8, rx);
    repeat (6) @(negedge clk_50m);
    total++; if (strobe_cnt - c0 !== 0) $display("FAIL mr_no_decode: got %0d want 0", strobe_cnt - c0); else pass_cnt++;
    total++; if (sif.miso_oe !== 1'b0) $display("FAIL mr_oe_held_low: got %b want 0", sif.miso_oe); else pass_cnt++;
    cs_high();
    cs_low();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h3C, 8, rx);
    cs_high();
    total++; if (strobe_cnt - c0 !== 1) $display("FAIL mr_new_strobe: got %0d want 1", strobe_cnt - c0); else pass_cnt++;
    total++; if (last_addr !== 7'h01) $display("FAIL mr_new_addr: got %h want 01", last_addr); else pass_cnt++;
    total++; if (last_data !== 8'h3C) $display("FAIL mr_new_data: got %h want 3c", last_data); else pass_cnt++;
    cs_low();
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h00, 8, rx);
    total++; if (rx !== 8'h00) $display("FAIL mr_reg0_cleared: got %h want 00", rx); else pass_cnt++;
    spi_bits(8'h00, 8, rx);
    total++; if (rx !== 8'h3C) $display("FAIL mr_reg1: got %h want 3c", rx); else pass_cnt++;
    cs_high();
  endtask
  initial begin
    test_reset();
    test_single_write();
    test_burst_write();
    test_burst_read();
    test_status();
    test_abort();
    test_midframe_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
